// File: rtl/block_data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
//   Shared definitions for the block data memory:
//     mem_state_e : controller states (INIT sweep, IDLE, BUSY latency, DONE)
//     offset_w    : byte-offset width inside a block, log2(BLOCK_BYTES)
//     index_w     : block-index width, log2(NUM_BLOCKS)
//     count_w     : latency counter width, log2(LATENCY)+1
// -----------------------------------------------------------------------------
package data_memory_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  function automatic int offset_w(input int block_bytes);
    return $clog2(block_bytes);
  endfunction

  function automatic int index_w(input int num_blocks);
    return $clog2(num_blocks);
  endfunction

  function automatic int count_w(input int latency);
    return $clog2(latency) + 1;
  endfunction

endpackage

// File: rtl/block_data_memory_latency_counter.sv
// -----------------------------------------------------------------------------
// mem_latency_counter
//   Loadable down-counter that times the access latency of one request.
//   Ports:
//     clock, reset : rising-edge clock, synchronous active-high reset
//     load         : load load_value (takes priority over decrement)
//     load_value   : value to load
//     decrement    : count down by one, saturating at zero
//     zero         : count is zero
// -----------------------------------------------------------------------------
module mem_latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             decrement,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/block_data_memory.sv
// -----------------------------------------------------------------------------
// block_data_memory
//   Block-oriented data memory below the data cache. Serves whole-block reads
//   and byte-enabled block writes after a programmable latency, using the
//   read/write/busywait handshake. After reset every block is cleared by a
//   one-block-per-cycle sweep before requests are accepted.
//   Ports:
//     clock, reset : rising-edge clock, synchronous active-high reset
//     read, write  : request strobes, held until busywait falls
//     address      : block address
//     writedata    : write block, byte i on bits [8i+7:8i]
//     byteenable   : per-byte write mask (ignored on reads)
//     readdata     : registered read block, held until the next read commit
//     busywait     : high while initialising or serving a request
//     error        : one-cycle pulse when an illegal request completes
// -----------------------------------------------------------------------------
module block_data_memory
  import data_memory_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int NUM_BLOCKS  = 16,
  parameter int BADDR_W     = 28,
  parameter int LATENCY     = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic                     write,
  input  logic [BADDR_W-1:0]       address,
  input  logic [8*BLOCK_BYTES-1:0] writedata,
  input  logic [BLOCK_BYTES-1:0]   byteenable,
  output logic [8*BLOCK_BYTES-1:0] readdata,
  output logic                     busywait,
  output logic                     error
);

  localparam int BLK_W = 8 * BLOCK_BYTES;
  localparam int IDX_W = index_w(NUM_BLOCKS);
  localparam int CNT_W = count_w(LATENCY);

  mem_state_e state, state_next;

  logic [IDX_W-1:0]       sweep;
  logic [BLK_W-1:0]       mem [NUM_BLOCKS];

  // Operands captured at acceptance so input changes during BUSY are ignored.
  logic [IDX_W-1:0]       idx_q;
  logic [BLK_W-1:0]       wdata_q;
  logic [BLOCK_BYTES-1:0] be_q;
  logic                   wr_q;
  logic                   illegal_q;

  logic accept;
  logic commit;
  logic cnt_zero;
  logic req_illegal;

  // Compared one bit wider so NUM_BLOCKS is representable even when
  // BADDR_W equals the index width.
  assign req_illegal = (read & write) |
                       ({1'b0, address} >= (BADDR_W + 1)'(NUM_BLOCKS));
  assign accept      = (state == IDLE) & (read | write);
  assign commit      = (state == BUSY) & cnt_zero & ~reset;

  mem_latency_counter #(
    .CNT_W(CNT_W)
  ) u_latency (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (CNT_W'(LATENCY - 1)),
    .decrement  (state == BUSY),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busywait   = 1'b1;
    case (state)
      INIT: begin
        if (sweep == IDX_W'(NUM_BLOCKS - 1)) state_next = IDLE;
      end
      IDLE: begin
        busywait = read | write;
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        if (cnt_zero) state_next = DONE;
      end
      DONE: begin
        busywait   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sweep <= '0;
    end else if (state == INIT) begin
      sweep <= sweep + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      idx_q     <= address[IDX_W-1:0];
      wdata_q   <= writedata;
      be_q      <= byteenable;
      wr_q      <= write;
      illegal_q <= req_illegal;
    end
  end

  // Storage: the init sweep and write commits never coincide (INIT vs BUSY).
  always_ff @(posedge clock) begin
    if ((state == INIT) && !reset) begin
      mem[sweep] <= '0;
    end else if (commit && wr_q && !illegal_q) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata <= '0;
      error    <= 1'b0;
    end else begin
      error <= commit & illegal_q;
      if (commit) begin
        if (illegal_q) begin
          readdata <= '0;
        end else if (!wr_q) begin
          readdata <= mem[idx_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
module tb_block_data_memory;

  localparam time PERIOD = 10;

  logic         clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters. Instance B: LATENCY=1, NUM_BLOCKS=4.
  logic         reset_a = 1'b1, read_a = 1'b0, write_a = 1'b0;
  logic [27:0]  address_a = '0;
  logic [127:0] writedata_a = '0;
  logic [15:0]  byteenable_a = '0;
  logic [127:0] readdata_a;
  logic         busywait_a, error_a;

  logic         reset_b = 1'b1, read_b = 1'b0, write_b = 1'b0;
  logic [27:0]  address_b = '0;
  logic [127:0] writedata_b = '0;
  logic [15:0]  byteenable_b = '0;
  logic [127:0] readdata_b;
  logic         busywait_b, error_b;

  block_data_memory dut_a (
    .clock(clock), .reset(reset_a), .read(read_a), .write(write_a),
    .address(address_a), .writedata(writedata_a), .byteenable(byteenable_a),
    .readdata(readdata_a), .busywait(busywait_a), .error(error_a)
  );

  block_data_memory #(.BLOCK_BYTES(16), .NUM_BLOCKS(4), .BADDR_W(28), .LATENCY(1)) dut_b (
    .clock(clock), .reset(reset_b), .read(read_b), .write(write_b),
    .address(address_b), .writedata(writedata_b), .byteenable(byteenable_b),
    .readdata(readdata_b), .busywait(busywait_b), .error(error_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: block contents and last value seen on readdata.
  logic [127:0] mem_a [16];
  logic [127:0] mem_b [4];
  logic [127:0] last_a, last_b;

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] wd,
                                         input logic [15:0] be);
    logic [127:0] r = old;
    for (int i = 0; i < 16; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One handshake, starting at a falling edge: raise the request, count the
  // cycles busywait is high, sample readdata/error in the first low cycle,
  // drop the request and return at the next falling edge.
  task automatic access(input int which, input bit rd, input bit wr, input logic [27:0] addr,
                        input logic [127:0] wd, input logic [15:0] be,
                        output logic [127:0] rdata, output logic err, output int busy,
                        output time t_done);
    bit done = 0;
    if (which == 0) begin
      read_a = rd; write_a = wr; address_a = addr; writedata_a = wd; byteenable_a = be;
    end else begin
      read_b = rd; write_b = wr; address_b = addr; writedata_b = wd; byteenable_b = be;
    end
    busy = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      #1;
      if (((which == 0) ? busywait_a : busywait_b) === 1'b1) begin
        busy++;
        @(negedge clock);
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL handshake_timeout inst=%0d addr=%0d: busywait still high after 300 cycles",
               which, addr);
    end
    t_done = $time;
    rdata  = (which == 0) ? readdata_a : readdata_b;
    err    = (which == 0) ? error_a : error_b;
    read_a = 0; write_a = 0; read_b = 0; write_b = 0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [127:0] rd; logic e; int b; time t;
    for (int i = 0; i < 16; i++) mem_a[i] = '0;
    for (int i = 0; i < 4; i++) mem_b[i] = '0;
    last_a = '0; last_b = '0;
    @(negedge clock);
    reset_a = 1; reset_b = 1;
    @(negedge clock);
    #1;
    tests++; if (busywait_a !== 1'b1) begin fails++; $display("FAIL reset_busywait got=%b want=1", busywait_a); end
    tests++; if (readdata_a !== '0) begin fails++; $display("FAIL reset_readdata got=%h want=0", readdata_a); end
    tests++; if (error_a !== 1'b0) begin fails++; $display("FAIL reset_error got=%b want=0", error_a); end
    tests++; if (readdata_b !== '0) begin fails++; $display("FAIL reset_readdata_b got=%h want=0", readdata_b); end
    @(negedge clock);
    reset_a = 0; reset_b = 0;
    access(0, 0, 0, 28'd0, '0, '0, rd, e, b, t);
    tests++; if (b !== 16) begin fails++; $display("FAIL init_busy_cycles got=%0d want=16", b); end
    // Reset again and issue a read while the sweep is still running.
    reset_a = 1;
    @(negedge clock);
    reset_a = 0;
    access(0, 1, 0, 28'd0, '0, '0, rd, e, b, t);
    tests++; if (b !== 22) begin fails++; $display("FAIL read_during_init_busy got=%0d want=22", b); end
    tests++; if (rd !== '0 || e !== 1'b0) begin fails++; $display("FAIL read_during_init data=%h err=%b want 0/0", rd, e); end
    for (int blk = 1; blk < 16; blk++) begin
      access(0, 1, 0, 28'(blk), '0, '0, rd, e, b, t);
      tests++;
      if (rd !== '0 || e !== 1'b0 || b !== 6) begin
        fails++; $display("FAIL read_after_init blk=%0d data=%h err=%b busy=%0d want 0/0/6", blk, rd, e, b);
      end
    end
  endtask

  task automatic test_full_write_read();
    logic [127:0] rd; logic e; int b; time t;
    logic [127:0] v = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    access(0, 0, 1, 28'd3, v, 16'hFFFF, rd, e, b, t);
    mem_a[3] = merge(mem_a[3], v, 16'hFFFF);
    tests++; if (b !== 6 || e !== 1'b0) begin fails++; $display("FAIL full_write busy=%0d err=%b want 6/0", b, e); end
    tests++; if (rd !== last_a) begin fails++; $display("FAIL full_write_hold got=%h want=%h", rd, last_a); end
    access(0, 1, 0, 28'd3, '0, '0, rd, e, b, t);
    tests++; if (b !== 6) begin fails++; $display("FAIL full_read_busy got=%0d want=6", b); end
    tests++; if (rd !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
      fails++; $display("FAIL full_read_data got=%h want=00112233445566778899aabbccddeeff", rd);
    end
    last_a = rd;
  endtask

  task automatic test_byte_enable();
    logic [127:0] rd; logic e; int b; time t;
    access(0, 0, 1, 28'd3, {16{8'hAA}}, 16'h000F, rd, e, b, t);
    mem_a[3] = merge(mem_a[3], {16{8'hAA}}, 16'h000F);
    access(0, 1, 0, 28'd3, '0, '0, rd, e, b, t);
    tests++; if (rd !== 128'h00112233_44556677_8899AABB_AAAAAAAA || e !== 1'b0) begin
      fails++; $display("FAIL byteenable_read got=%h err=%b want=00112233445566778899aabbaaaaaaaa/0", rd, e);
    end
    last_a = rd;
  endtask

  task automatic test_illegal();
    logic [127:0] rd; logic e; int b; time t;
    access(0, 1, 1, 28'd2, {16{8'h5C}}, 16'hFFFF, rd, e, b, t);
    tests++; if (e !== 1'b1 || rd !== '0 || b !== 6) begin
      fails++; $display("FAIL illegal_rdwr err=%b data=%h busy=%0d want 1/0/6", e, rd, b);
    end
    access(0, 1, 0, 28'd20, '0, '0, rd, e, b, t);
    tests++; if (e !== 1'b1 || rd !== '0 || b !== 6) begin
      fails++; $display("FAIL illegal_addr err=%b data=%h busy=%0d want 1/0/6", e, rd, b);
    end
    // The error pulse lasts one cycle: the IDLE cycle after DONE shows it low.
    #1;
    tests++; if (error_a !== 1'b0) begin fails++; $display("FAIL error_pulse_width got=%b want=0", error_a); end
    access(0, 1, 0, 28'd2, '0, '0, rd, e, b, t);
    tests++; if (rd !== mem_a[2] || e !== 1'b0) begin fails++; $display("FAIL illegal_no_change blk2 got=%h want=%h", rd, mem_a[2]); end
    access(0, 1, 0, 28'd3, '0, '0, rd, e, b, t);
    tests++; if (rd !== mem_a[3]) begin fails++; $display("FAIL illegal_no_change blk3 got=%h want=%h", rd, mem_a[3]); end
    last_a = rd;
  endtask

  task automatic test_reset_mid_write();
    logic [127:0] rd; logic e; int b; time t;
    logic [127:0] v = {$urandom, $urandom, $urandom, $urandom};
    access(0, 0, 1, 28'd5, v, 16'hFFFF, rd, e, b, t);
    access(0, 1, 0, 28'd5, '0, '0, rd, e, b, t);
    tests++; if (rd !== v) begin fails++; $display("FAIL premid_write got=%h want=%h", rd, v); end
    // Second write accepted at the next edge E0; reset sampled at E0+3.
    write_a = 1; address_a = 28'd5; writedata_a = ~v; byteenable_a = 16'hFFFF;
    repeat (3) @(negedge clock);
    reset_a = 1; write_a = 0;
    @(negedge clock);
    reset_a = 0;
    for (int i = 0; i < 16; i++) mem_a[i] = '0;
    last_a = '0;
    access(0, 1, 0, 28'd5, '0, '0, rd, e, b, t);
    tests++; if (b !== 22) begin fails++; $display("FAIL reset_mid_busy got=%0d want=22", b); end
    tests++; if (rd !== '0 || e !== 1'b0) begin fails++; $display("FAIL reset_mid_read got=%h err=%b want 0/0", rd, e); end
    access(0, 1, 0, 28'd3, '0, '0, rd, e, b, t);
    tests++; if (rd !== '0) begin fails++; $display("FAIL reset_mid_wipe blk3 got=%h want=0", rd); end
  endtask

  task automatic test_random();
    logic [127:0] rd, wd, exp_d; logic e, exp_e; int b; time t;
    logic [27:0] addr; logic [15:0] be; bit r, w, ill;
    for (int n = 0; n < 40; n++) begin
      int k = $urandom_range(0, 9);
      r = (k < 4) || (k == 9);
      w = (k >= 4);
      case ($urandom_range(0, 7))
        0:       addr = 28'(16 + $urandom_range(0, 200));
        1:       addr = 28'hFFFFFFF;
        default: addr = 28'($urandom_range(0, 15));
      endcase
      wd = {$urandom, $urandom, $urandom, $urandom};
      be = 16'($urandom);
      ill = (r && w) || (addr >= 16);
      exp_e = ill;
      if (ill) exp_d = '0;
      else if (r) exp_d = mem_a[addr[3:0]];
      else begin exp_d = last_a; mem_a[addr[3:0]] = merge(mem_a[addr[3:0]], wd, be); end
      access(0, r, w, addr, wd, be, rd, e, b, t);
      tests++;
      if (rd !== exp_d || e !== exp_e || b !== 6) begin
        fails++;
        $display("FAIL random n=%0d r=%0b w=%0b addr=%0d data=%h err=%b busy=%0d want %h/%b/6",
                 n, r, w, addr, rd, e, b, exp_d, exp_e);
      end
      last_a = exp_d;
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] rd, wd, exp_d; logic e, exp_e; int b; time t, prev_t;
    logic [27:0] addr; logic [15:0] be; bit r, w;
    prev_t = 0;
    for (int n = 0; n < 24; n++) begin
      if (n < 4)       begin r = 0; w = 1; addr = 28'(n); be = 16'hFFFF; end
      else if (n < 8)  begin r = 1; w = 0; addr = 28'(n - 4); be = '0; end
      else if (n == 8) begin r = 1; w = 0; addr = 28'd4; be = '0; end
      else begin
        r = $urandom_range(0, 1); w = !r; addr = 28'($urandom_range(0, 3)); be = 16'($urandom);
      end
      wd = {$urandom, $urandom, $urandom, $urandom};
      exp_e = (addr >= 4);
      if (exp_e) exp_d = '0;
      else if (r) exp_d = mem_b[addr[1:0]];
      else begin exp_d = last_b; mem_b[addr[1:0]] = merge(mem_b[addr[1:0]], wd, be); end
      access(1, r, w, addr, wd, be, rd, e, b, t);
      tests++;
      if (rd !== exp_d || e !== exp_e || b !== 2) begin
        fails++;
        $display("FAIL b2b n=%0d r=%0b w=%0b addr=%0d data=%h err=%b busy=%0d want %h/%b/2",
                 n, r, w, addr, rd, e, b, exp_d, exp_e);
      end
      if (n > 0) begin
        tests++;
        if (t - prev_t != 3 * PERIOD) begin
          fails++; $display("FAIL b2b_spacing n=%0d got=%0t want=%0t", n, t - prev_t, 3 * PERIOD);
        end
      end
      prev_t = t;
      last_b = exp_d;
    end
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_byte_enable();
    test_illegal();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
